// File: rtl/bip_control.sv
// BIP1 control unit: fetch/exec sequencer, PC and instruction decode for the accumulator datapath.
// Optional executed-cycle counter enabled by defining BIP_CYCLE_COUNT_EN.
module bip_control #(
    parameter int NB_DATA    = 16,
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_ADDR    = 11,
    parameter int NB_COUNT   = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [NB_DATA-1:0]    i_instruction,
    output logic [NB_ADDR-1:0]    o_pc_addr,
    output logic [1:0]            o_SelA,
    output logic                  o_SelB,
    output logic                  o_WrAcc,
    output logic                  o_op,
    output logic [NB_OPERAND-1:0] o_operand,
    output logic                  o_WrRam,
    output logic                  o_RdRam,
    output logic                  o_halt,
    output logic [NB_COUNT-1:0]   o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(0);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(1);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(2);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(3);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(4);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(6);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(7);

    state_t              state;
    state_t              state_next;
    logic [NB_ADDR-1:0]  pc;
    logic [NB_OPCODE-1:0] opcode;

    assign opcode    = i_instruction[NB_DATA-1 -: NB_OPCODE];
    assign o_pc_addr = pc;
    assign o_halt    = (state == HALT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // PC only advances on a completed non-halt EXEC; it wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc <= '0;
        end else if (state == EXEC && opcode != OP_HLT) begin
            pc <= pc + NB_ADDR'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = FETCH;
            FETCH:   state_next = EXEC;
            EXEC:    state_next = (opcode == OP_HLT) ? HALT : FETCH;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_SelA    = 2'b00;
        o_SelB    = 1'b0;
        o_WrAcc   = 1'b0;
        o_op      = 1'b0;
        o_WrRam   = 1'b0;
        o_RdRam   = 1'b0;
        o_operand = '0;
        if (state == EXEC) begin
            o_operand = i_instruction[NB_OPERAND-1:0];
            case (opcode)
                OP_STO: o_WrRam = 1'b1;
                OP_LD: begin
                    o_WrAcc = 1'b1;
                    o_RdRam = 1'b1;
                end
                OP_LDI: begin
                    o_SelA  = 2'b01;
                    o_WrAcc = 1'b1;
                end
                OP_ADD: begin
                    o_SelA  = 2'b10;
                    o_WrAcc = 1'b1;
                    o_RdRam = 1'b1;
                end
                OP_ADDI: begin
                    o_SelA  = 2'b10;
                    o_SelB  = 1'b1;
                    o_WrAcc = 1'b1;
                end
                OP_SUB: begin
                    o_SelA  = 2'b10;
                    o_op    = 1'b1;
                    o_WrAcc = 1'b1;
                    o_RdRam = 1'b1;
                end
                OP_SUBI: begin
                    o_SelA  = 2'b10;
                    o_SelB  = 1'b1;
                    o_op    = 1'b1;
                    o_WrAcc = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [NB_COUNT-1:0] cycle_count;

    // Counts only active fetch/exec cycles and sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cycle_count <= '0;
        end else if ((state == FETCH || state == EXEC) && cycle_count != '1) begin
            cycle_count <= cycle_count + NB_COUNT'(1);
        end
    end

    assign o_cycle_count = cycle_count;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit for the BIP1 accumulator core.
- Fetches 16-bit instructions from a synchronous-read program ROM and decodes them into the datapath's control inputs.
- Sequences the program counter and flags halt.
- Its outputs are exactly the select, write-enable, op and operand signals the datapath consumes; it also drives the data-RAM read/write strobes.

Parameters:
- NB_DATA, 16, instruction width.
- NB_OPCODE, 5, opcode field width, instruction[15:11].
- NB_OPERAND, 11, operand field width, instruction[10:0].
- NB_ADDR, 11, program counter / ROM address width.
- NB_COUNT, 32, cycle counter width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_start  in  1  begin execution from PC=0; sampled only in IDLE.
- i_instruction  in  NB_DATA  ROM data; valid the cycle after o_pc_addr is presented.
- o_pc_addr  out  NB_ADDR  ROM address (current PC).
- o_SelA  out  2  datapath mux A: 00 memory, 01 sign-extended operand, 10 ALU result.
- o_SelB  out  1  datapath mux B: 0 memory, 1 sign-extended operand.
- o_WrAcc  out  1  accumulator write enable.
- o_op  out  1  ALU op: 0 add, 1 subtract.
- o_operand  out  NB_OPERAND  instruction[10:0]; used as immediate and as data-RAM address.
- o_WrRam  out  1  data-RAM write strobe (STO).
- o_RdRam  out  1  data-RAM read strobe (LD/ADD/SUB).
- o_halt  out  1  high while in HALT.
- o_cycle_count  out  NB_COUNT  executed-cycle count (see Optional Feature).

Behaviour:
- Reset:
  - State goes to IDLE and PC to 0; effective the edge i_rst is sampled high, from any state.
  - All outputs are 0 after that edge.
- States:
  - IDLE: wait for i_start=1, then go to FETCH.
  - FETCH: present PC on o_pc_addr; the ROM registers the instruction; go to EXEC.
  - EXEC: decode i_instruction; drive controls for exactly this one cycle.
    - HLT: go to HALT; PC unchanged.
    - Any other opcode: PC <= PC+1, then go to FETCH.
  - HALT: terminal until i_rst; i_start is ignored.
- Throughput: 2 cycles per instruction.
- PC arithmetic: NB_ADDR-bit unsigned. 2047+1 wraps to 0 with no flag.
- Control outputs:
  - Combinational from state and i_instruction.
  - All 0 outside EXEC.
  - o_operand = i_instruction[10:0] in EXEC, otherwise 0.
- Decode in EXEC (unlisted outputs = 0):
  - 00000 HLT: none.
  - 00001 STO: WrRam=1.
  - 00010 LD: SelA=00, WrAcc=1, RdRam=1.
  - 00011 LDI: SelA=01, WrAcc=1.
  - 00100 ADD: SelA=10, SelB=0, op=0, WrAcc=1, RdRam=1.
  - 00101 ADDI: SelA=10, SelB=1, op=0, WrAcc=1.
  - 00110 SUB: SelA=10, SelB=0, op=1, WrAcc=1, RdRam=1.
  - 00111 SUBI: SelA=10, SelB=1, op=1, WrAcc=1.
  - 01000–11111: NOP. All controls 0; PC still increments; no halt.
- Data RAM: asynchronous read, write on the EXEC clock edge. No extra wait states.
- Simultaneous events:
  - i_rst has priority over i_start and over any EXEC transition.
  - i_start held high across a run has no effect after leaving IDLE.
- o_pc_addr is registered PC; it is stable during both FETCH and EXEC of an instruction.

Optional Feature:
- Macro: BIP_CYCLE_COUNT_EN.
- Defined: o_cycle_count is a register.
  - Cleared by reset.
  - Increments by 1 each cycle the FSM is in FETCH or EXEC.
  - Holds in IDLE/HALT.
  - Saturates at all-ones.
- Undefined: o_cycle_count tied to 0; no counter logic. The port list is identical in both builds.

Test Plan:
- Program run: ROM = {0x1805 LDI 5, 0x2803 ADDI 3, 0x0000 HLT}; reset, then i_start pulse.
  - EXEC #1: SelA=01, WrAcc=1, operand=5.
  - EXEC #2: SelA=10, SelB=1, op=0, WrAcc=1, operand=3.
  - Then o_halt=1 with o_pc_addr=2 held.
  - With BIP_CYCLE_COUNT_EN: o_cycle_count=6.
- SUB: instruction 0x3010 -> EXEC drives SelA=10, SelB=0, op=1, WrAcc=1, RdRam=1, operand=0x010, WrRam=0.
- STO: instruction 0x0805 -> WrRam=1, WrAcc=0, RdRam=0, operand=5, for exactly one cycle.
- Illegal/NOP and wrap: ROM filled with 0x4000.
  - All controls 0 in every EXEC; o_halt stays 0.
  - After 2048 instructions, o_pc_addr returns to 0.
- Reset mid-run: assert i_rst during EXEC of ADD (0x2007) -> next cycle state IDLE, PC=0, WrAcc=0, o_cycle_count=0.
- HALT lock: in HALT, pulse i_start -> no state change and o_pc_addr constant. Only i_rst then i_start restarts from PC=0.
